// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the mac command front-end.
//   OP_*      : 3-bit opcodes understood by the mac datapath
//   MAC_LAT   : mac output delay, counted in issues
//   mac_cmd_t : one queued command {instr, a (multiplier), b (multiplicand)}
package mac_pkg;

  localparam logic [2:0] OP_CLR16 = 3'b000;
  localparam logic [2:0] OP_MUL16 = 3'b001;
  localparam logic [2:0] OP_MAC16 = 3'b010;
  localparam logic [2:0] OP_SAT16 = 3'b011;
  localparam logic [2:0] OP_CLR8  = 3'b100;
  localparam logic [2:0] OP_MUL8  = 3'b101;
  localparam logic [2:0] OP_MAC8  = 3'b110;
  localparam logic [2:0] OP_SAT8  = 3'b111;

  localparam int MAC_LAT = 2;

  typedef struct packed {
    logic [2:0]  instr;
    logic [15:0] a;
    logic [15:0] b;
  } mac_cmd_t;

endpackage

// File: rtl/mac_issue_ctrl_fifo.sv
// mac_cmd_fifo -- synchronous command FIFO, DEPTH entries (power of two, >=2).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_push, i_data    : write request and command (ignored while full)
//   i_pop             : remove head (ignored while empty)
//   o_head            : current head entry (combinational read)
//   o_empty, o_full   : occupancy flags derived from the entry count
module mac_cmd_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  mac_cmd_t i_data,
  input  logic     i_pop,
  output mac_cmd_t o_head,
  output logic     o_empty,
  output logic     o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mac_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // The head must be visible in the cycle it is issued, so the read is
  // combinational; storage itself needs no reset because the count gates it.
  assign o_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl -- command front-end for the 16x16 / dual-8x8 mac datapath.
// Buffers commands, issues the FIFO head to the mac (owning its stall), tracks
// opcodes through the mac's LAT-issue output pipeline and presents the result
// as a valid/ready response tagged with its opcode.
// Optional build macro: MAC_ISSUE_PERF_EN enables perf_issued / perf_blocked.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_instr/a/b  : command handshake and payload
//   mac_instruction/multiplier/
//   multiplicand, mac_stall             : mac drive (head of FIFO, 0 when empty)
//   mac_protect, mac_result             : mac output registers
//   rsp_valid/rsp_ready, rsp_instr,
//   rsp_protect, rsp_result             : tagged response
//   perf_issued, perf_blocked           : performance counters (0 when disabled)
module mac_issue_ctrl
  import mac_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = MAC_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_instr,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [2:0]  mac_instruction,
  output logic [15:0] mac_multiplier,
  output logic [15:0] mac_multiplicand,
  output logic        mac_stall,
  input  logic [7:0]  mac_protect,
  input  logic [31:0] mac_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_instr,
  output logic [7:0]  rsp_protect,
  output logic [31:0] rsp_result,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_blocked
);

  mac_cmd_t   w_cmd;
  mac_cmd_t   w_head;
  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_issue;
  logic       r_rsp_valid;
  logic [2:0] r_rsp_instr;

  assign w_cmd  = '{instr: cmd_instr, a: cmd_a, b: cmd_b};
  assign w_push = cmd_valid && !w_full;

  mac_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_cmd),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // An issue advances the whole mac, including its output register, so it is
  // only allowed once any pending response has been (or is being) taken.
  assign w_issue   = !w_empty && (!r_rsp_valid || rsp_ready);
  assign mac_stall = !w_issue;
  assign cmd_ready = !w_full;

  assign mac_instruction  = w_empty ? 3'd0  : w_head.instr;
  assign mac_multiplier   = w_empty ? 16'd0 : w_head.a;
  assign mac_multiplicand = w_empty ? 16'd0 : w_head.b;

  // Tag pipeline mirrors the mac's output delay; it only moves on issue.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
    logic       w_v_in;
    logic [2:0] w_instr_in;
    logic       r_v;
    logic [2:0] r_instr;

    if (gi == 0) begin : g_first
      assign w_v_in     = 1'b1;
      assign w_instr_in = w_head.instr;
    end else begin : g_rest
      assign w_v_in     = g_tag[gi-1].r_v;
      assign w_instr_in = g_tag[gi-1].r_instr;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v     <= 1'b0;
        r_instr <= '0;
      end else if (w_issue) begin
        r_v     <= w_v_in;
        r_instr <= w_instr_in;
      end
    end
  end

  // The entry leaving the last tag stage lines up with the mac output
  // register that the same issue edge loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
    end else if (w_issue) begin
      r_rsp_valid <= g_tag[LAT-1].r_v;
      r_rsp_instr <= g_tag[LAT-1].r_instr;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_instr   = r_rsp_instr;
  assign rsp_protect = mac_protect;
  assign rsp_result  = mac_result;

`ifdef MAC_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_blocked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_issued  <= '0;
      r_perf_blocked <= '0;
    end else begin
      if (w_issue) r_perf_issued <= r_perf_issued + 32'd1;
      if (!w_empty && r_rsp_valid && !rsp_ready) r_perf_blocked <= r_perf_blocked + 32'd1;
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_blocked = r_perf_blocked;
`else
  assign perf_issued  = 32'd0;
  assign perf_blocked = 32'd0;
`endif

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb_mac_issue_ctrl -- directed test-plan scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model. A behavioural
// mac stand-in supplies mac_protect / mac_result.
module tb_mac_issue_ctrl;
  import mac_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = MAC_LAT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_instr = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [2:0]  mac_instruction;
  logic [15:0] mac_multiplier;
  logic [15:0] mac_multiplicand;
  logic        mac_stall;
  logic [7:0]  mac_protect;
  logic [31:0] mac_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_instr;
  logic [7:0]  rsp_protect;
  logic [31:0] rsp_result;
  logic [31:0] perf_issued;
  logic [31:0] perf_blocked;

  always #5 clk = ~clk;

  mac_issue_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_instr        (cmd_instr),
    .cmd_a            (cmd_a),
    .cmd_b            (cmd_b),
    .mac_instruction  (mac_instruction),
    .mac_multiplier   (mac_multiplier),
    .mac_multiplicand (mac_multiplicand),
    .mac_stall        (mac_stall),
    .mac_protect      (mac_protect),
    .mac_result       (mac_result),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_instr        (rsp_instr),
    .rsp_protect      (rsp_protect),
    .rsp_result       (rsp_result),
    .perf_issued      (perf_issued),
    .perf_blocked     (perf_blocked)
  );

  // ---------------- behavioural mac arithmetic ----------------
  // Packed form: protect = {hi_guard, lo_guard} in 8-bit mode, acc[39:32] in 16-bit mode.
  function automatic logic [39:0] pack8(input logic signed [19:0] hi, input logic signed [19:0] lo);
    return {hi[19:16], lo[19:16], hi[15:0], lo[15:0]};
  endfunction

  function automatic logic signed [19:0] sat20(input logic signed [19:0] v);
    if (v > 20'sh07FFF) return 20'sh07FFF;
    if (v < -20'sh08000) return -20'sh08000;
    return v;
  endfunction

  function automatic logic [39:0] mac_eval(input logic [39:0] acc, input mac_cmd_t c);
    logic signed [39:0] wide, p16;
    logic signed [19:0] hi, lo, ph, pl;
    logic [39:0] r;
    wide = acc;
    hi   = {acc[39:36], acc[31:16]};
    lo   = {acc[35:32], acc[15:0]};
    p16  = 40'($signed(c.a)) * 40'($signed(c.b));
    ph   = 20'($signed(c.a[15:8])) * 20'($signed(c.b[15:8]));
    pl   = 20'($signed(c.a[7:0])) * 20'($signed(c.b[7:0]));
    case (c.instr)
      OP_CLR16: r = '0;
      OP_MUL16: r = p16;
      OP_MAC16: r = wide + p16;
      OP_SAT16: r = (wide > 40'sh007FFFFFFF) ? 40'h007FFFFFFF :
                    (wide < -40'sh0080000000) ? 40'hFF80000000 : wide;
      OP_CLR8:  r = '0;
      OP_MUL8:  r = pack8(ph, pl);
      OP_MAC8:  r = pack8(hi + ph, lo + pl);
      default:  r = pack8(sat20(hi), sat20(lo));
    endcase
    return r;
  endfunction

  // mac stand-in: advances only when not stalled; output shows the op issued
  // LAT issues earlier. Shares the controller's reset.
  mac_cmd_t    s_cmd;
  logic [39:0] s_acc;
  logic [39:0] s_hist [LAT+1];
  assign s_cmd = '{instr: mac_instruction, a: mac_multiplier, b: mac_multiplicand};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_acc <= '0;
      for (int i = 0; i <= LAT; i++) s_hist[i] <= '0;
    end else if (!mac_stall) begin
      s_acc     <= mac_eval(s_acc, s_cmd);
      s_hist[0] <= mac_eval(s_acc, s_cmd);
      for (int i = 1; i <= LAT; i++) s_hist[i] <= s_hist[i-1];
    end
  end
  assign mac_protect = s_hist[LAT][39:32];
  assign mac_result  = s_hist[LAT][31:0];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  instr;
    logic [39:0] res;
  } rsp_t;

  mac_cmd_t    m_fifo [$];
  rsp_t        m_fly  [$];
  rsp_t        rsp_log [$];
  logic        m_rsp_valid;
  rsp_t        m_rsp;
  logic [39:0] m_acc;
  int          m_issued;
  int          m_blocked;
  int          n_issue_seen;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    m_fly.delete();
    m_rsp_valid = 1'b0;
    m_rsp       = '0;
    m_acc       = '0;
    m_issued    = 0;
    m_blocked   = 0;
  endtask

  // One clock: drive at negedge, compare to model, then advance model at posedge.
  task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy);
    mac_cmd_t c, head;
    logic exp_full, exp_issue, exp_block;
    @(negedge clk);
    cmd_valid = v; cmd_instr = op; cmd_a = a; cmd_b = b; rsp_ready = rdy;
    #1;
    exp_full  = (m_fifo.size() == DEPTH);
    exp_issue = (m_fifo.size() != 0) && (!m_rsp_valid || rdy);
    exp_block = (m_fifo.size() != 0) && m_rsp_valid && !rdy;
    head      = (m_fifo.size() != 0) ? m_fifo[0] : '0;
    check_eq("cmd_ready", cmd_ready, !exp_full);
    check_eq("mac_stall", mac_stall, !exp_issue);
    check_eq("mac_head", {mac_instruction, mac_multiplier, mac_multiplicand}, head);
    check_eq("rsp_valid", rsp_valid, m_rsp_valid);
    if (m_rsp_valid) begin
      check_eq("rsp_instr", rsp_instr, m_rsp.instr);
      check_eq("rsp_data", {rsp_protect, rsp_result}, m_rsp.res);
    end
`ifdef MAC_ISSUE_PERF_EN
    check_eq("perf_issued", perf_issued, 32'(m_issued));
    check_eq("perf_blocked", perf_blocked, 32'(m_blocked));
`else
    check_eq("perf_issued", perf_issued, 0);
    check_eq("perf_blocked", perf_blocked, 0);
`endif
    if (!mac_stall) n_issue_seen++;
    if (rsp_valid && rdy) begin
      rsp_log.push_back('{instr: rsp_instr, res: {rsp_protect, rsp_result}});
      $display("rsp instr=%0d protect=%02h result=%08h", rsp_instr, rsp_protect, rsp_result);
    end
    @(posedge clk);
    if (exp_block) m_blocked++;
    if (exp_issue) begin
      c     = m_fifo.pop_front();
      m_acc = mac_eval(m_acc, c);
      m_fly.push_back('{instr: c.instr, res: m_acc});
      m_issued++;
      if (m_fly.size() > LAT) begin
        m_rsp       = m_fly.pop_front();
        m_rsp_valid = 1'b1;
      end else begin
        m_rsp_valid = 1'b0;
      end
    end else if (rdy) begin
      m_rsp_valid = 1'b0;
    end
    if (v && !exp_full) m_fifo.push_back('{instr: op, a: a, b: b});
  endtask

  // Assert reset between clock edges and check its effect before any edge.
  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_mac_stall", mac_stall, 1);
    check_eq("rst_mac_head", {mac_instruction, mac_multiplier, mac_multiplicand}, 0);
    check_eq("rst_rsp_instr", rsp_instr, 0);
    check_eq("rst_perf", {perf_issued, perf_blocked}, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    rsp_log.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'd0, 16'd0, rdy);
  endtask

  int seen0;

  initial begin
    model_clear();
    n_issue_seen = 0;

    // Single multiply: 3 x -4
    do_reset();
    cycle(1, OP_MUL16, 16'd3, 16'hFFFC, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    idle(3, 1);
    check_eq("mul16_nrsp", rsp_log.size(), 1);
    if (rsp_log.size() >= 1) begin
      check_eq("mul16_instr", rsp_log[0].instr, OP_MUL16);
      check_eq("mul16_data", rsp_log[0].res, 40'hFF_FFFFFFF4);
    end

    // Accumulate: 3 x -4 then + 2 x 5
    do_reset();
    cycle(1, OP_MUL16, 16'd3, 16'hFFFC, 1);
    cycle(1, OP_MAC16, 16'd2, 16'd5, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    idle(3, 1);
    check_eq("mac16_nrsp", rsp_log.size(), 2);
    if (rsp_log.size() >= 2) begin
      check_eq("mac16_instr", rsp_log[1].instr, OP_MAC16);
      check_eq("mac16_data", rsp_log[1].res, 40'hFF_FFFFFFFE);
    end

    // Dual 8x8
    do_reset();
    cycle(1, OP_MUL8, 16'h02FD, 16'h0304, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 1);
    idle(3, 1);
    check_eq("mul8_nrsp", rsp_log.size(), 1);
    if (rsp_log.size() >= 1) begin
      check_eq("mul8_instr", rsp_log[0].instr, OP_MUL8);
      check_eq("mul8_data", rsp_log[0].res, 40'h0F_0006FFF4);
    end

    // Back-pressure and full: response 7x9 pending, then 5 pushes
    do_reset();
    cycle(1, OP_MUL16, 16'd7, 16'd9, 0);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 0);
    cycle(1, OP_MUL16, 16'd0, 16'd0, 0);
    idle(1, 0);
    seen0 = n_issue_seen;
    for (int i = 0; i < 4; i++) cycle(1, OP_MAC16, 16'(i + 1), 16'd2, 0);
    #1;
    check_eq("bp_full_after4", cmd_ready, 0);
    cycle(1, OP_MAC16, 16'd9, 16'd9, 0);
    #1;
    check_eq("bp_full_after5", cmd_ready, 0);
    check_eq("bp_stall", mac_stall, 1);
    check_eq("bp_rsp_hold", {rsp_protect, rsp_result}, 40'h00_0000003F);
    check_eq("bp_no_issue", n_issue_seen - seen0, 0);
    seen0 = n_issue_seen;
    idle(4, 1);
    check_eq("bp_resume_rate", n_issue_seen - seen0, 4);

    // Reset mid-stream: 3 queued, 2 in flight, 1 response pending
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, OP_MUL16, 16'(i + 2), 16'd3, 0);
    do_reset();
    cycle(1, OP_MUL16, 16'd1, 16'd1, 1);
    cycle(1, OP_MUL16, 16'd2, 16'd2, 1);
    cycle(0, 3'd0, 16'd0, 16'd0, 1);
    #1;
    check_eq("rst_mid_no_rsp", rsp_valid, 0);
    idle(2, 1);

    // Perf: 6 issues, 3 blocked cycles
    do_reset();
    cycle(1, OP_MUL16, 16'd1, 16'd1, 0);
    cycle(1, OP_MUL16, 16'd2, 16'd2, 0);
    cycle(1, OP_MUL16, 16'd3, 16'd3, 0);
    idle(1, 0);
    cycle(1, OP_MUL16, 16'd4, 16'd4, 0);
    cycle(1, OP_MUL16, 16'd5, 16'd5, 0);
    cycle(1, OP_MUL16, 16'd6, 16'd6, 0);
    idle(1, 0);
    idle(3, 1);
    #1;
`ifdef MAC_ISSUE_PERF_EN
    check_eq("perf_issued_6", perf_issued, 6);
    check_eq("perf_blocked_3", perf_blocked, 3);
`else
    check_eq("perf_issued_off", perf_issued, 0);
    check_eq("perf_blocked_off", perf_blocked, 0);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) != 0);
    end
    idle(8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
